serial_tx_driver: RTL
=====================

// Module: serial_tx_driver
//
// PURPOSE
//   Bit-serial transmitter that drives the d input of a downstream posedge
//   capture flop. It accepts a parallel word through a valid/ready handshake
//   and serialises it as: start(0), DATA_W data bits LSB first, optional
//   parity, stop(1). Each bit is held for CLKS_PER_BIT clocks. The line idles
//   high.
//
// PARAMETERS
//   DATA_W        8   width of the parallel word; legal range 1..16
//   CLKS_PER_BIT  4   clocks per serial bit; must be >= 1
//
// PORTS
//   clk       input   1       rising-edge clock; all state changes on posedge
//   reset     input   1       synchronous, active-high reset
//   tx_data   input   DATA_W  word to send; sampled only on handshake
//   tx_valid  input   1       word on tx_data is valid
//   tx_ready  output  1       block can accept a word (high only in IDLE)
//   tx_out    output  1       serial line, registered, idle high
//   tx_busy   output  1       frame in progress (any state other than IDLE)
//
// BEHAVIOUR
//   - Reset (reset=1 at posedge): state=IDLE, tx_out=1, tx_ready=1,
//     tx_busy=0; bit counter and clock-divider counter cleared.
//   - Reset has priority over every other event, including mid-frame: the
//     frame aborts, tx_out=1 after that edge, and no partial bits are resent.
//   - Handshake: transfer on the posedge where tx_valid&&tx_ready. At that
//     edge tx_data is latched into the shift register, state goes to START,
//     tx_ready=0, tx_busy=1 and tx_out=0.
//   - tx_data and tx_valid are ignored while tx_ready=0; changes to tx_data
//     never corrupt the frame in flight.
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     Each of START, each DATA bit, PARITY and STOP lasts exactly CLKS_PER_BIT
//     clocks. The divider counts 0..CLKS_PER_BIT-1; bit advance happens on
//     terminal count.
//   - DATA: bit i (i = 0..DATA_W-1) is driven in order; the bit counter wraps
//     to 0 on leaving DATA.
//   - STOP: tx_out=1. On terminal count go to IDLE; tx_ready=1 and tx_busy=0
//     after that edge.
//   - Minimum spacing: one IDLE clock between frames. With tx_valid held high,
//     frames start every (DATA_W+2[+1])*CLKS_PER_BIT + 1 clocks.
//   - tx_out is driven straight from a flop, never from combinational logic,
//     so a posedge sampler sees stable bits.
//   - CLKS_PER_BIT=1 must work: one bit per clock, with no skipped or
//     duplicated bits.
//
// CONFIGURATION
//   SERIAL_TX_PARITY_EN
//   - Defined: a PARITY state follows DATA and drives the even-parity bit
//     (^data_latched), so the count of ones over data plus parity is even.
//     Frame length is DATA_W+3 bits.
//   - Undefined: no PARITY state and no parity logic; DATA goes straight to
//     STOP. Frame length is DATA_W+2 bits.
//
// TESTING (DATA_W=8, CLKS_PER_BIT=4 unless stated)
//   1. Reset held for 3 clks -> tx_out=1, tx_ready=1, tx_busy=0; these hold
//      with tx_valid=0.
//   2. Send 0xA5 -> tx_out per 4-clk bit is 0,1,0,1,0,0,1,0,1,1 (40 clks);
//      tx_ready=1 on the clk after the stop bit ends.
//   3. Hold tx_valid=1 and change tx_data to 0xFF mid-frame -> the 0xA5 frame
//      is unchanged. The next frame sends the value present at the next
//      handshake, and starts 41 clks after the first.
//   4. Assert reset during the 4th data bit -> tx_out=1 next edge, IDLE; a
//      fresh 0x3C afterwards is sent intact.
//   5. CLKS_PER_BIT=1, send 0x01 -> tx_out per clk is 0,1,0,0,0,0,0,0,0,1.
//   6. With SERIAL_TX_PARITY_EN, 0xA5 -> parity bit 0 (44 clks); 0x07 ->
//      parity bit 1.

Source files
------------

// File: rtl/serial_tx_driver.sv
// serial_tx_driver: bit-serial transmitter with a valid/ready word input.
// A frame is start(0), DATA_W data bits LSB first, optional even parity, then
// stop(1). Each bit is held for CLKS_PER_BIT clocks and the line idles high.
// Build option: define SERIAL_TX_PARITY_EN to add the even-parity bit.
module serial_tx_driver #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  div_cnt, div_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [DATA_W-1:0] data_q;
  logic              out_d;
  logic              div_term;

  assign div_term = (div_cnt == DIV_LAST);

  // State, counters and the line flop; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_out  <= 1'b1;
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      tx_out  <= out_d;
    end
  end

  // Word capture on handshake only, so later tx_data changes cannot leak in.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && tx_valid)
      data_q <= tx_data;
  end

  // Next state: each bit period ends on divider terminal count.
  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    if (state == S_IDLE) begin
      if (tx_valid) begin
        state_d = S_START;
        div_d   = '0;
        bit_d   = '0;
      end
    end else if (div_term) begin
      div_d = '0;
      case (state)
        S_START: state_d = S_DATA;
        S_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: state_d = S_STOP;
`endif
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else begin
      div_d = div_cnt + 1'b1;
    end
  end

  // Outputs: the line value is computed for the upcoming state and registered,
  // so tx_out changes exactly on the edge that enters each bit.
  always_comb begin
    tx_ready = (state == S_IDLE);
    tx_busy  = (state != S_IDLE);
    out_d    = 1'b1;
    case (state_d)
      S_IDLE:   out_d = 1'b1;
      S_START:  out_d = 1'b0;
      S_DATA:   out_d = data_q[bit_d];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: out_d = ^data_q;
`endif
      S_STOP:   out_d = 1'b1;
      default:  out_d = 1'b1;
    endcase
  end

endmodule
